fetch_pc_ctrl: RTL and testbench

//  IF stage: owns the PC, issues instruction-memory requests and drives the IF/ID pipeline register.

---
 rtl/fetch_pc_ctrl.sv | 138 +++++++++++++
 tb/tb_fetch_pc_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_ctrl.sv
// IF stage: owns the PC, issues single-outstanding instruction fetches and drives IF/ID.
// Redirects flush IF/ID and retire stale in-flight responses by epoch tag; stalls park a response in a hold buffer.
module fetch_pc_ctrl #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pcsrc_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic            stall_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            id_valid_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic [XLEN-1:0] id_pc_plus4_o,
  output logic [31:0]     id_instr_o,
  output logic            misalign_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic            r_epoch;
  logic            r_req_tag;
  logic            r_run;
  logic [31:0]     r_hold_instr;
  logic            r_id_valid;
  logic [XLEN-1:0] r_id_pc;
  logic [XLEN-1:0] r_id_pc_plus4;
  logic [31:0]     r_id_instr;
  logic            r_misalign;

  logic            w_req;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_target_aligned;
  logic            w_tag_match;
  logic            w_accept;
  logic            w_load_mem;
  logic            w_load_hold;

  // r_run keeps the request line low while reset is asserted and for the first cycle after release.
  assign w_req            = r_run & (r_state == ST_IDLE);
  assign w_pc_plus4       = r_pc + XLEN'(4);
  assign w_target_aligned = {branch_target_i[XLEN-1:2], 2'b00};
  assign w_tag_match      = (r_req_tag == r_epoch);
  assign w_accept         = (r_state == ST_WAIT) & imem_rvalid_i & w_tag_match & ~pcsrc_i;
  assign w_load_mem       = w_accept & ~stall_i;
  assign w_load_hold      = (r_state == ST_HOLD) & ~stall_i & ~pcsrc_i;

  always_comb begin
    // NOTE: default assignment first so no path leaves w_state_nxt unassigned (no latch).
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (r_run) w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        // A response that arrives with a redirect or a stale tag is simply dropped.
        if (imem_rvalid_i) w_state_nxt = (w_accept && stall_i) ? ST_HOLD : ST_IDLE;
      end
      ST_HOLD: if (pcsrc_i || !stall_i) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_run     <= 1'b0;
      r_pc      <= RESET_PC;
      r_epoch   <= 1'b0;
      r_req_tag <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= 1'b1;
      if (w_req) r_req_tag <= r_epoch;
      if (pcsrc_i) begin
        r_pc    <= w_target_aligned;
        r_epoch <= ~r_epoch;
      end else if (w_load_mem || w_load_hold) begin
        r_pc <= w_pc_plus4;
      end
    end
  end

  // NOTE: the hold buffer is data-only, but it is reset anyway so IF/ID can never be loaded with X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_instr <= NOP_INSTR;
    end else if (pcsrc_i) begin
      r_hold_instr <= NOP_INSTR;
    end else if (w_accept && stall_i) begin
      r_hold_instr <= imem_rdata_i;
    end
  end

  // An unstalled cycle with nothing new to hand over inserts a bubble so decode never sees a word twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id_valid    <= 1'b0;
      r_id_pc       <= '0;
      r_id_pc_plus4 <= '0;
      r_id_instr    <= NOP_INSTR;
    end else if (pcsrc_i) begin
      r_id_valid <= 1'b0;
      r_id_instr <= NOP_INSTR;
    end else if (w_load_mem || w_load_hold) begin
      r_id_valid    <= 1'b1;
      r_id_pc       <= r_pc;
      r_id_pc_plus4 <= w_pc_plus4;
      r_id_instr    <= w_load_mem ? imem_rdata_i : r_hold_instr;
    end else if (!stall_i) begin
      r_id_valid <= 1'b0;
      r_id_instr <= NOP_INSTR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_misalign <= 1'b0;
    else        r_misalign <= pcsrc_i & (|branch_target_i[1:0]);
  end

  assign imem_req_o    = w_req;
  assign imem_addr_o   = w_req ? r_pc : '0;
  assign id_valid_o    = r_id_valid;
  assign id_pc_o       = r_id_pc;
  assign id_pc_plus4_o = r_id_pc_plus4;
  assign id_instr_o    = r_id_instr;
  assign misalign_o    = r_misalign;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: a variable-latency memory model plus a scoreboard of accepted fetches
// that are compared against IF/ID when they reach decode.
`timescale 1ns/1ps
module tb_fetch_pc_ctrl;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pcsrc_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        stall_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_pc_plus4_o;
  logic [31:0] id_instr_o;
  logic        misalign_o;

  fetch_pc_ctrl #(.XLEN(32), .RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pcsrc_i        (pcsrc_i),
    .branch_target_i(branch_target_i),
    .stall_i        (stall_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_rvalid_i  (imem_rvalid_i),
    .imem_rdata_i   (imem_rdata_i),
    .id_valid_o     (id_valid_o),
    .id_pc_o        (id_pc_o),
    .id_pc_plus4_o  (id_pc_plus4_o),
    .id_instr_o     (id_instr_o),
    .misalign_o     (misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  fetch_t      exp_q[$];
  fetch_t      e;
  int          n_cmp = 0;
  int          n_err = 0;
  int          mem_lat = 1;

  logic        m_out = 1'b0, m_killed = 1'b0, m_held = 1'b0;
  logic [31:0] m_addr = '0, exp_addr = RESET_PC;
  int          m_cnt = 0;
  logic        s_req = 1'b0;
  logic [31:0] s_addr = '0;
  logic        prev_pcsrc = 1'b0, prev_stall = 1'b0;
  logic [31:0] prev_target = '0;
  logic        snap_valid = 1'b0;
  logic [31:0] snap_pc = '0, snap_pc4 = '0, snap_instr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA0 + (a >> 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Memory model and scoreboard: bookkeeping at the rising edge, outputs sampled and memory driven at the falling edge.
  always begin
    @(posedge clk);
    if (!rst_n) begin
      m_out = 1'b0; m_killed = 1'b0; m_held = 1'b0; m_cnt = 0;
      exp_addr = RESET_PC;
      exp_q.delete();
      prev_pcsrc = 1'b0; prev_stall = 1'b0; prev_target = '0;
    end else begin
      if (s_req) begin
        check("req_addr", s_addr, exp_addr);
        check("one_outstanding", {31'b0, m_out}, 32'd0);
        check("no_req_in_hold", {31'b0, m_held}, 32'd0);
      end
      if (imem_rvalid_i && m_out) begin
        m_out = 1'b0;
        if (!m_killed && !pcsrc_i) begin
          e.pc    = m_addr;
          e.instr = mem_word(m_addr);
          exp_q.push_back(e);
          if (stall_i) m_held = 1'b1;
          else         exp_addr = m_addr + 32'd4;
        end
      end else if (m_held && !stall_i && !pcsrc_i) begin
        m_held   = 1'b0;
        exp_addr = m_addr + 32'd4;
      end
      if (pcsrc_i) begin
        if (m_out) m_killed = 1'b1;
        m_held = 1'b0;
        exp_q.delete();
        exp_addr = {branch_target_i[31:2], 2'b00};
      end
      if (s_req) begin
        m_out    = 1'b1;
        m_addr   = s_addr;
        m_killed = pcsrc_i;
        m_cnt    = mem_lat;
      end
      prev_pcsrc  = pcsrc_i;
      prev_stall  = stall_i;
      prev_target = branch_target_i;
    end

    @(negedge clk);
    imem_rvalid_i = 1'b0;
    if (!rst_n) begin
      s_req  = 1'b0;
      s_addr = '0;
    end else begin
      check("misalign", {31'b0, misalign_o}, {31'b0, prev_pcsrc & (|prev_target[1:0])});
      if (prev_pcsrc) begin
        check("flush_valid", {31'b0, id_valid_o}, 32'd0);
        check("flush_instr", id_instr_o, NOP);
      end else if (prev_stall) begin
        check("stall_valid", {31'b0, id_valid_o}, {31'b0, snap_valid});
        check("stall_pc", id_pc_o, snap_pc);
        check("stall_pc4", id_pc_plus4_o, snap_pc4);
        check("stall_instr", id_instr_o, snap_instr);
      end else if (id_valid_o) begin
        if (exp_q.size() == 0) begin
          check("valid_without_fetch", {31'b0, id_valid_o}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("id_pc", id_pc_o, e.pc);
          check("id_pc_plus4", id_pc_plus4_o, e.pc + 32'd4);
          check("id_instr", id_instr_o, e.instr);
        end
      end
      snap_valid = id_valid_o;
      snap_pc    = id_pc_o;
      snap_pc4   = id_pc_plus4_o;
      snap_instr = id_instr_o;
      if (m_out && m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = mem_word(m_addr);
        end
      end
      s_req  = imem_req_o;
      s_addr = imem_addr_o;
    end
  end

  task automatic check_reset();
    check("rst_req", {31'b0, imem_req_o}, 32'd0);
    check("rst_addr", imem_addr_o, 32'd0);
    check("rst_valid", {31'b0, id_valid_o}, 32'd0);
    check("rst_pc", id_pc_o, 32'd0);
    check("rst_pc4", id_pc_plus4_o, 32'd0);
    check("rst_instr", id_instr_o, NOP);
    check("rst_misalign", {31'b0, misalign_o}, 32'd0);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_req();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!imem_req_o && k < 50);
    if (!imem_req_o) check("req_timeout", {31'b0, imem_req_o}, 32'd1);
    #1;
  endtask

  task automatic wait_rvalid();
    int k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (!imem_rvalid_i && k < 50);
    if (!imem_rvalid_i) check("rvalid_timeout", {31'b0, imem_rvalid_i}, 32'd1);
  endtask

  task automatic redirect(input logic [31:0] t);
    pcsrc_i = 1'b1;
    branch_target_i = t;
    @(negedge clk);
    #1;
    pcsrc_i = 1'b0;
  endtask

  initial begin
    #12;
    check_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Sequential fetch at 1-cycle latency.
    mem_lat = 1;
    cycles(12);

    // Stall while a 2-cycle response lands.
    mem_lat = 2;
    wait_req();
    stall_i = 1'b1;
    cycles(4);
    stall_i = 1'b0;
    cycles(6);

    // Redirect while a 3-cycle fetch is in flight.
    mem_lat = 3;
    wait_req();
    cycles(1);
    redirect(32'h0000_0100);
    cycles(12);

    // Redirect in the same cycle as the response.
    mem_lat = 1;
    wait_rvalid();
    redirect(32'h0000_0180);
    cycles(8);

    // Redirect while stalled with a word parked in the hold buffer.
    wait_req();
    stall_i = 1'b1;
    cycles(3);
    redirect(32'h0000_0240);
    cycles(2);
    stall_i = 1'b0;
    cycles(8);

    // Misaligned target.
    wait_req();
    redirect(32'h0000_0203);
    cycles(8);

    // PC wrap at the top of the address space.
    wait_req();
    redirect(32'hFFFF_FFFC);
    cycles(10);

    // Asynchronous reset in the middle of an outstanding fetch.
    mem_lat = 3;
    wait_req();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset();
    cycles(2);
    rst_n = 1'b1;
    mem_lat = 1;
    cycles(10);

    check("drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

endmodule
